// File: rtl/optical_flow_seq_pkg.sv
// Shared types and helpers for the optical-flow frame sequencer.
// Holds the bank index type, the sequencer state encoding and the free-bank picker.
package optical_flow_seq_pkg;

    localparam int NUM_BANKS = 3;

    typedef logic [1:0]           bank_t;
    typedef logic [NUM_BANKS-1:0] bank_mask_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FLOW  = 2'd3
    } seq_state_e;

    // Lowest-index bank whose bit is set in free_mask; 0 when nothing is free.
    function automatic bank_t next_free_bank(input bank_mask_t free_mask);
        bank_t sel;
        sel = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                sel = bank_t'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/optical_flow_bank_rot.sv
// Image bank bookkeeping for the triple buffer.
// Tracks which bank holds the current (img) frame, the previous (prev) frame and the
// single pending frame, plus the set of banks the loader may overwrite.
module optical_flow_bank_rot
    import optical_flow_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
    input  logic       start,
    input  logic       rotate,
    output logic [1:0] load_bank,
    output logic       any_free,
    output logic       pending,
    output logic       have_prev,
    output logic [1:0] img_bank,
    output logic [1:0] prev_bank
);

    bank_t      cur_reg;
    bank_t      prv_reg;
    bank_t      pend_bank_reg;
    logic       pend_valid_reg;
    logic       have_prev_reg;
    bank_mask_t free_reg;
    bank_mask_t free_next;
    bank_t      load_sel;

    assign load_sel = next_free_bank(free_reg);

    // A bank leaves the free set when the loader fills it and returns when its frame
    // is no longer needed as the reference (the old prev bank on rotation).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_free
            assign free_next[gi] = (free_reg[gi] && !(accept && load_sel == bank_t'(gi)))
                                 || (rotate && prv_reg == bank_t'(gi));
        end
    endgenerate

    // Bank role registers: accept fills prev (first frame) or pending, start promotes
    // pending to cur, rotate makes cur the new reference.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_reg        <= '0;
            prv_reg        <= '0;
            pend_bank_reg  <= '0;
            pend_valid_reg <= 1'b0;
            have_prev_reg  <= 1'b0;
            free_reg       <= '1;
        end else begin
            free_reg <= free_next;
            if (accept) begin
                if (have_prev_reg) begin
                    pend_bank_reg  <= load_sel;
                    pend_valid_reg <= 1'b1;
                end else begin
                    prv_reg       <= load_sel;
                    have_prev_reg <= 1'b1;
                end
            end
            if (start) begin
                cur_reg        <= pend_bank_reg;
                pend_valid_reg <= 1'b0;
            end
            if (rotate) begin
                prv_reg <= cur_reg;
            end
        end
    end

    assign load_bank = load_sel;
    assign any_free  = |free_reg;
    assign pending   = pend_valid_reg;
    assign have_prev = have_prev_reg;
    assign img_bank  = cur_reg;
    assign prev_bank = prv_reg;

endmodule

// File: rtl/optical_flow_frame_seq.sv
// Frame scheduler in front of the optical_flow_hls core (ap_ctrl_hs handshake).
// Directs the loader into a free image bank, starts the core on the img/prev pair,
// holds the flow result until the consumer acks it and then rotates bank roles.
// Optional build macro OF_SEQ_PERF_EN adds run-length and ack-stall counters.
module optical_flow_frame_seq #(
    parameter int FRAME_ID_W = 16,
    parameter int NUM_BANKS  = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  enable,
    output logic                  load_ready,
    output logic [1:0]            load_bank,
    input  logic                  load_done,
    output logic                  core_start,
    input  logic                  core_ready,
    input  logic                  core_done,
    input  logic                  core_idle,
    output logic [1:0]            img_bank,
    output logic [1:0]            prev_bank,
    output logic                  flow_valid,
    input  logic                  flow_ack,
    output logic [FRAME_ID_W-1:0] flow_frame_id,
    output logic                  busy
`ifdef OF_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_run_cycles,
    output logic [31:0]           perf_stall_cycles
`endif
);

    import optical_flow_seq_pkg::*;

    generate
        if (NUM_BANKS != optical_flow_seq_pkg::NUM_BANKS) begin : g_bank_check
            $error("optical_flow_frame_seq: NUM_BANKS must be 3");
        end
    endgenerate

    seq_state_e            state_reg;
    seq_state_e            state_next;
    logic [FRAME_ID_W-1:0] frame_id_reg;
    logic [FRAME_ID_W-1:0] flow_frame_id_reg;
    logic                  accept;
    logic                  start_go;
    logic                  done_hit;
    logic                  rotate_go;
    logic                  any_free;
    logic                  pending;
    logic                  have_prev;
    logic                  core_idle_unused;

    // The sequencer relies on ap_ready/ap_done alone; ap_idle carries no extra information.
    assign core_idle_unused = core_idle;

    assign load_ready = any_free && enable && !pending;
    assign accept     = load_done && load_ready;

    optical_flow_bank_rot u_bank_rot (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .accept    (accept),
        .start     (start_go),
        .rotate    (rotate_go),
        .load_bank (load_bank),
        .any_free  (any_free),
        .pending   (pending),
        .have_prev (have_prev),
        .img_bank  (img_bank),
        .prev_bank (prev_bank)
    );

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and strobes; ap_start stays high in START until ap_ready is seen.
    always_comb begin
        state_next = state_reg;
        core_start = 1'b0;
        start_go   = 1'b0;
        done_hit   = 1'b0;
        rotate_go  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pending && have_prev && enable) begin
                    state_next = START;
                    start_go   = 1'b1;
                end
            end
            START: begin
                core_start = 1'b1;
                if (core_ready) begin
                    if (core_done) begin
                        state_next = FLOW;
                        done_hit   = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (core_done) begin
                    state_next = FLOW;
                    done_hit   = 1'b1;
                end
            end
            FLOW: begin
                if (flow_ack) begin
                    state_next = IDLE;
                    rotate_go  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame counters: result id is the frame just computed; frame id advances on ack.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            frame_id_reg      <= '0;
            flow_frame_id_reg <= '0;
        end else begin
            if (done_hit) begin
                flow_frame_id_reg <= frame_id_reg + 1'b1;
            end
            if (rotate_go) begin
                frame_id_reg <= frame_id_reg + 1'b1;
            end
        end
    end

    assign flow_valid    = (state_reg == FLOW);
    assign flow_frame_id = flow_frame_id_reg;
    assign busy          = (state_reg != IDLE) || pending;

`ifdef OF_SEQ_PERF_EN
    logic [31:0] run_cnt_reg;
    logic [31:0] perf_run_reg;
    logic [31:0] perf_stall_reg;

    // Run length from START entry through the core_done cycle; stall counts FLOW cycles
    // without ack and saturates at all-ones.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            run_cnt_reg    <= '0;
            perf_run_reg   <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (start_go) begin
                run_cnt_reg <= '0;
            end else if (state_reg == START || state_reg == RUN) begin
                run_cnt_reg <= run_cnt_reg + 32'd1;
            end
            if (done_hit) begin
                perf_run_reg <= run_cnt_reg + 32'd1;
            end
            if (state_reg == FLOW && !flow_ack && perf_stall_reg != 32'hFFFF_FFFF) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_run_cycles   = perf_run_reg;
    assign perf_stall_cycles = perf_stall_reg;
`endif

endmodule

// File: tb/tb_optical_flow_frame_seq.sv
// Self-checking bench for optical_flow_frame_seq: directed scenarios plus a randomized
// run against a frame-level model (which frames occupy which banks).
module tb_optical_flow_frame_seq;

    localparam int FW = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          enable;
    logic          load_ready;
    logic [1:0]    load_bank;
    logic          load_done;
    logic          core_start;
    logic          core_ready;
    logic          core_done;
    logic          core_idle;
    logic [1:0]    img_bank;
    logic [1:0]    prev_bank;
    logic          flow_valid;
    logic          flow_ack;
    logic [FW-1:0] flow_frame_id;
    logic          busy;
`ifdef OF_SEQ_PERF_EN
    logic [31:0]   perf_run_cycles;
    logic [31:0]   perf_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // Frame-level model state: bank holding each loaded frame, oldest frame still needed.
    int bank_of[$];
    int oldest;

    always #5 ap_clk = ~ap_clk;

    optical_flow_frame_seq #(.FRAME_ID_W(FW), .NUM_BANKS(3)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .enable        (enable),
        .load_ready    (load_ready),
        .load_bank     (load_bank),
        .load_done     (load_done),
        .core_start    (core_start),
        .core_ready    (core_ready),
        .core_done     (core_done),
        .core_idle     (core_idle),
        .img_bank      (img_bank),
        .prev_bank     (prev_bank),
        .flow_valid    (flow_valid),
        .flow_ack      (flow_ack),
        .flow_frame_id (flow_frame_id),
        .busy          (busy)
`ifdef OF_SEQ_PERF_EN
        ,
        .perf_run_cycles   (perf_run_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Lowest bank not holding any frame from oldest..newest loaded; -1 if none.
    function automatic int model_free_bank();
        for (int b = 0; b < 3; b++) begin
            bit used = 1'b0;
            for (int f = oldest; f < bank_of.size(); f++) begin
                if (bank_of[f] == b) used = 1'b1;
            end
            if (!used) return b;
        end
        return -1;
    endfunction

    task automatic test_reset();
        ap_rst_n = 1'b0; enable = 1'b0;
        step(); step();
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_core_start got=%0b exp=0", core_start); end
        checks++; if (flow_valid !== 1'b0) begin errors++; $display("FAIL rst_flow_valid got=%0b exp=0", flow_valid); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready got=%0b exp=0", load_ready); end
        checks++; if (load_bank !== 2'd0) begin errors++; $display("FAIL rst_load_bank got=%0d exp=0", load_bank); end
        checks++; if (img_bank !== 2'd0 || prev_bank !== 2'd0) begin errors++; $display("FAIL rst_banks got img=%0d prev=%0d exp 0/0", img_bank, prev_bank); end
        checks++; if (flow_frame_id !== 16'd0) begin errors++; $display("FAIL rst_frame_id got=%0d exp=0", flow_frame_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        ap_rst_n = 1'b1;
        step();
    endtask

    task automatic test_first_frame();
        enable = 1'b1;
        #1;
        checks++; if (load_ready !== 1'b1 || load_bank !== 2'd0) begin errors++; $display("FAIL t1_offer got ready=%0b bank=%0d exp 1/0", load_ready, load_bank); end
        load_done = 1'b1; step(); load_done = 1'b0;
        checks++; if (prev_bank !== 2'd0) begin errors++; $display("FAIL t1_prev_bank got=%0d exp=0", prev_bank); end
        checks++; if (load_bank !== 2'd1 || load_ready !== 1'b1) begin errors++; $display("FAIL t1_next_offer got bank=%0d ready=%0b exp 1/1", load_bank, load_ready); end
        step(); step();
        checks++; if (core_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_no_start got start=%0b busy=%0b exp 0/0", core_start, busy); end
    endtask

    task automatic test_second_frame();
        load_done = 1'b1; step(); load_done = 1'b0;
        checks++; if (core_start !== 1'b0 || load_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t2_pending got start=%0b ready=%0b busy=%0b exp 0/0/1", core_start, load_ready, busy); end
        step();
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL t2_start_latency got=%0b exp=1", core_start); end
        checks++; if (img_bank !== 2'd1 || prev_bank !== 2'd0) begin errors++; $display("FAIL t2_banks got img=%0d prev=%0d exp 1/0", img_bank, prev_bank); end
        checks++; if (load_ready !== 1'b1 || load_bank !== 2'd2) begin errors++; $display("FAIL t2_third_offer got ready=%0b bank=%0d exp 1/2", load_ready, load_bank); end
        step(); step();
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL t2_start_held got=%0b exp=1", core_start); end
        core_ready = 1'b1; step(); core_ready = 1'b0;
        checks++; if (core_start !== 1'b0 || flow_valid !== 1'b0) begin errors++; $display("FAIL t2_run got start=%0b flow=%0b exp 0/0", core_start, flow_valid); end
    endtask

    task automatic test_overlap();
        load_done = 1'b1; step(); load_done = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL t3_backpressure got=%0b exp=0", load_ready); end
        flow_ack = 1'b1; step(); flow_ack = 1'b0;
        checks++; if (flow_valid !== 1'b0 || core_start !== 1'b0) begin errors++; $display("FAIL t3_stray_ack got flow=%0b start=%0b exp 0/0", flow_valid, core_start); end
        core_done = 1'b1; step(); core_done = 1'b0;
        checks++; if (flow_valid !== 1'b1 || flow_frame_id !== 16'd1) begin errors++; $display("FAIL t3_result got flow=%0b id=%0d exp 1/1", flow_valid, flow_frame_id); end
        core_done = 1'b1; step(); core_done = 1'b0;
        step(); step();
        checks++; if (flow_valid !== 1'b1 || flow_frame_id !== 16'd1 || core_start !== 1'b0) begin errors++; $display("FAIL t3_flow_hold got flow=%0b id=%0d start=%0b exp 1/1/0", flow_valid, flow_frame_id, core_start); end
        flow_ack = 1'b1; step(); flow_ack = 1'b0;
        checks++; if (flow_valid !== 1'b0 || prev_bank !== 2'd1) begin errors++; $display("FAIL t3_rotate got flow=%0b prev=%0d exp 0/1", flow_valid, prev_bank); end
        checks++; if (load_bank !== 2'd0 || load_ready !== 1'b0) begin errors++; $display("FAIL t3_freed got bank=%0d ready=%0b exp 0/0", load_bank, load_ready); end
        step();
        checks++; if (core_start !== 1'b1 || img_bank !== 2'd2 || prev_bank !== 2'd1) begin errors++; $display("FAIL t3_restart got start=%0b img=%0d prev=%0d exp 1/2/1", core_start, img_bank, prev_bank); end
        checks++; if (load_ready !== 1'b1 || load_bank !== 2'd0) begin errors++; $display("FAIL t3_offer got ready=%0b bank=%0d exp 1/0", load_ready, load_bank); end
    endtask

    task automatic test_ready_done_same();
        int nbad = 0;
        core_ready = 1'b1; core_done = 1'b1; step(); core_ready = 1'b0; core_done = 1'b0;
        checks++; if (flow_valid !== 1'b1 || flow_frame_id !== 16'd2 || core_start !== 1'b0) begin errors++; $display("FAIL t4_direct_flow got flow=%0b id=%0d start=%0b exp 1/2/0", flow_valid, flow_frame_id, core_start); end
        step();
        flow_ack = 1'b1; step(); flow_ack = 1'b0;
        checks++; if (flow_valid !== 1'b0 || prev_bank !== 2'd2 || busy !== 1'b0) begin errors++; $display("FAIL t4_ack got flow=%0b prev=%0d busy=%0b exp 0/2/0", flow_valid, prev_bank, busy); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (flow_valid !== 1'b0 || core_start !== 1'b0) nbad++;
        end
        checks++; if (nbad != 0) begin errors++; $display("FAIL t4_single_result got %0d active cycles exp 0", nbad); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        load_done = 1'b1; step(); load_done = 1'b0;
        while (core_start !== 1'b1 && n < 10) begin step(); n++; end
        checks++; if (core_start !== 1'b1 || img_bank !== 2'd0 || prev_bank !== 2'd2) begin errors++; $display("FAIL t5_start got start=%0b img=%0d prev=%0d exp 1/0/2", core_start, img_bank, prev_bank); end
        core_ready = 1'b1; step(); core_ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_running got busy=%0b exp 1", busy); end
        ap_rst_n = 1'b0; enable = 1'b0; step();
        checks++; if (core_start !== 1'b0 || flow_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0) begin errors++; $display("FAIL t5_ctrl got start=%0b flow=%0b busy=%0b ready=%0b exp 0/0/0/0", core_start, flow_valid, busy, load_ready); end
        checks++; if (img_bank !== 2'd0 || prev_bank !== 2'd0 || load_bank !== 2'd0 || flow_frame_id !== 16'd0) begin errors++; $display("FAIL t5_data got img=%0d prev=%0d load=%0d id=%0d exp 0/0/0/0", img_bank, prev_bank, load_bank, flow_frame_id); end
        ap_rst_n = 1'b1; enable = 1'b1; step();
    endtask

    task automatic test_enable_hold();
        int n = 0;
        int nbad = 0;
        load_done = 1'b1; step(); load_done = 1'b0;
        load_done = 1'b1; step(); load_done = 1'b0;
        while (core_start !== 1'b1 && n < 10) begin step(); n++; end
        checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL t6_start_timeout got=%0b exp=1", core_start); end
        core_ready = 1'b1; step(); core_ready = 1'b0;
        checks++; if (load_bank !== 2'd2 || load_ready !== 1'b1) begin errors++; $display("FAIL t6_offer got bank=%0d ready=%0b exp 2/1", load_bank, load_ready); end
        load_done = 1'b1; step(); load_done = 1'b0;
        enable = 1'b0;
        core_done = 1'b1; step(); core_done = 1'b0;
        checks++; if (flow_valid !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL t6_completes got flow=%0b ready=%0b exp 1/0", flow_valid, load_ready); end
        flow_ack = 1'b1; step(); flow_ack = 1'b0;
        checks++; if (flow_valid !== 1'b0) begin errors++; $display("FAIL t6_ack got flow=%0b exp 0", flow_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (core_start !== 1'b0) nbad++;
        end
        checks++; if (nbad != 0 || busy !== 1'b1) begin errors++; $display("FAIL t6_hold got starts=%0d busy=%0b exp 0/1", nbad, busy); end
        enable = 1'b1; step();
        checks++; if (core_start !== 1'b1 || img_bank !== 2'd2 || prev_bank !== 2'd1) begin errors++; $display("FAIL t6_resume got start=%0b img=%0d prev=%0d exp 1/2/1", core_start, img_bank, prev_bank); end
        core_ready = 1'b1; core_done = 1'b1; step(); core_ready = 1'b0; core_done = 1'b0;
        flow_ack = 1'b1; step(); flow_ack = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || flow_frame_id !== 16'd2) begin errors++; $display("FAIL t6_drain got busy=%0b id=%0d exp 0/2", busy, flow_frame_id); end
    endtask

    task automatic test_random();
        int  started = 0;
        int  rstate = 0;
        int  delay = 0;
        int  mfree;
        int  s;
        bit  en_prev;
        bit  exp_fv = 1'b0;
        bit  id_checked = 1'b0;
        bit  exp_ready;
        bit  do_load;
        bit  do_done;
        bit  do_ack;
        bank_of.delete();
        oldest = 0;
        ap_rst_n = 1'b0; enable = 1'b1;
        step();
        ap_rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            en_prev = enable;
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            #1;
            // A new core run: check it was allowed and uses the right bank pair.
            if (core_start === 1'b1 && rstate == 0) begin
                s = started + 1;
                checks++;
                if (!en_prev || s >= bank_of.size()) begin
                    errors++; $display("FAIL rnd_start_allowed cyc=%0d enable=%0b frame=%0d loaded=%0d", cyc, en_prev, s, bank_of.size());
                end else begin
                    checks++; if (img_bank !== bank_of[s] || prev_bank !== bank_of[s-1]) begin errors++; $display("FAIL rnd_banks cyc=%0d frame=%0d got img=%0d prev=%0d exp %0d/%0d", cyc, s, img_bank, prev_bank, bank_of[s], bank_of[s-1]); end
                end
                started = s;
                rstate = 1;
                delay = $urandom_range(0, 3);
            end
            checks++; if (core_start !== (rstate == 1)) begin errors++; $display("FAIL rnd_core_start cyc=%0d got=%0b exp=%0b", cyc, core_start, rstate == 1); end
            mfree = model_free_bank();
            exp_ready = enable && (mfree >= 0) && !(bank_of.size() - 1 > started);
            checks++; if (load_ready !== exp_ready) begin errors++; $display("FAIL rnd_load_ready cyc=%0d got=%0b exp=%0b", cyc, load_ready, exp_ready); end
            if (exp_ready) begin
                checks++; if (load_bank !== mfree) begin errors++; $display("FAIL rnd_load_bank cyc=%0d got=%0d exp=%0d", cyc, load_bank, mfree); end
            end
            checks++; if (flow_valid !== exp_fv) begin errors++; $display("FAIL rnd_flow_valid cyc=%0d got=%0b exp=%0b", cyc, flow_valid, exp_fv); end
            if (exp_fv && !id_checked) begin
                checks++; if (flow_frame_id !== FW'(started)) begin errors++; $display("FAIL rnd_frame_id cyc=%0d got=%0d exp=%0d", cyc, flow_frame_id, started); end
                id_checked = 1'b1;
            end
            // Drive the loader, core and consumer for this cycle.
            do_load = exp_ready ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            do_done = 1'b0;
            core_ready = 1'b0;
            core_done = 1'b0;
            if (rstate == 1) begin
                if (delay == 0) begin
                    core_ready = 1'b1;
                    if ($urandom_range(0, 3) == 0) begin
                        do_done = 1'b1; rstate = 0;
                    end else begin
                        rstate = 2; delay = $urandom_range(0, 4);
                    end
                end else begin
                    delay--;
                end
            end else if (rstate == 2) begin
                if (delay == 0) begin
                    do_done = 1'b1; rstate = 0;
                end else begin
                    delay--;
                end
            end
            core_done = do_done || (rstate == 0 && $urandom_range(0, 9) == 0);
            do_ack = exp_fv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            load_done = do_load;
            flow_ack = do_ack;
            if (do_load && exp_ready) bank_of.push_back(mfree);
            if (do_ack && exp_fv) begin
                exp_fv = 1'b0;
                oldest++;
            end
            if (do_done) begin
                exp_fv = 1'b1;
                id_checked = 1'b0;
            end
        end
        load_done = 1'b0; core_ready = 1'b0; core_done = 1'b0; flow_ack = 1'b0;
        checks++; if (started < 20) begin errors++; $display("FAIL rnd_progress got %0d frames exp >=20", started); end
    endtask

    initial begin
        ap_rst_n = 1'b0; enable = 1'b0; load_done = 1'b0; core_ready = 1'b0;
        core_done = 1'b0; core_idle = 1'b1; flow_ack = 1'b0;
        test_reset();
        test_first_frame();
        test_second_frame();
        test_overlap();
        test_ready_done_same();
        test_reset_mid();
        test_enable_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
